divider32_seq: RTL and testbench

- Multi-cycle unsigned 32-bit restoring divider for the calculator pipeline; the inverse operation to the adder datapath.
- Accepts dividend/divisor over a valid/ready request channel and iterates one quotient bit per clock.
- Returns quotient and remainder over a valid/ready response channel.
- Each iteration's trial subtraction is performed by a ripple-borrow subtractor sub-module built from full adders.

---
 rtl/calculator_pkg.sv | 13 +
 rtl/full_adder.sv | 13 +
 rtl/subtractor32.sv | 30 +++
 rtl/divider32_seq.sv | 130 +++++++++++++
 tb/tb_divider32_seq.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/calculator_pkg.sv
// Shared types and sizing constants for the calculator datapath blocks.
package calculator_pkg;

    localparam int DIV_DATA_W = 32;
    localparam int DIV_CNT_W  = $clog2(DIV_DATA_W) + 1;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder, the building cell of the ripple subtractor.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));

endmodule

// File: rtl/subtractor32.sv
// Ripple-borrow subtractor: diff = a - b computed as a + ~b + 1.
// borrow_o is set when b > a (unsigned), i.e. the final carry is clear.
module subtractor32
    import calculator_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] diff_o,
    output logic              borrow_o
);

    logic [DATA_W:0] carry_s;

    assign carry_s[0] = 1'b1;

    for (genvar i = 0; i < DATA_W; i++) begin : g_fa
        full_adder u_fa (
            .a_i  (a_i[i]),
            .b_i  (~b_i[i]),
            .ci_i (carry_s[i]),
            .s_o  (diff_o[i]),
            .co_o (carry_s[i+1])
        );
    end

    assign borrow_o = ~carry_s[DATA_W];

endmodule

// File: rtl/divider32_seq.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// A zero divisor short-circuits straight to DONE with all-ones quotient
// and the dividend as remainder, flagged by div_by_zero_o.
module divider32_seq
    import calculator_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int CNT_W  = DIV_CNT_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [DATA_W-1:0] dividend_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] quotient_o,
    output logic [DATA_W-1:0] remainder_o,
    output logic              div_by_zero_o
);

    div_state_e        state_r;
    logic [DATA_W-1:0] quot_r;
    logic [DATA_W-1:0] rem_r;
    logic [DATA_W-1:0] div_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              req_ready_r;
    logic              resp_valid_r;
    logic [DATA_W-1:0] quotient_r;
    logic [DATA_W-1:0] remainder_r;
    logic              dbz_r;

    logic              carry_s;
    logic [DATA_W-1:0] rem_sh_s;
    logic [DATA_W-1:0] trial_s;
    logic              borrow_s;
    logic [DATA_W-1:0] rem_next_s;
    logic [DATA_W-1:0] quot_next_s;

    // Trial subtraction of the divisor from the shifted partial remainder.
    subtractor32 #(.DATA_W(DATA_W)) u_sub (
        .a_i      (rem_sh_s),
        .b_i      (div_r),
        .diff_o   (trial_s),
        .borrow_o (borrow_s)
    );

    // One restoring step: shift in the next dividend bit, keep the trial
    // result when it fits (the shifted-out carry means it always fits).
    always_comb begin
        {carry_s, rem_sh_s} = {rem_r, quot_r[DATA_W-1]};
        if (carry_s || !borrow_s) begin
            rem_next_s  = trial_s;
            quot_next_s = {quot_r[DATA_W-2:0], 1'b1};
        end else begin
            rem_next_s  = rem_sh_s;
            quot_next_s = {quot_r[DATA_W-2:0], 1'b0};
        end
    end

    // Control FSM with iteration datapath and registered handshake/result outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= DIV_IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            quotient_r   <= {DATA_W{1'b0}};
            remainder_r  <= {DATA_W{1'b0}};
            dbz_r        <= 1'b0;
            cnt_r        <= {CNT_W{1'b0}};
            quot_r       <= {DATA_W{1'b0}};
            rem_r        <= {DATA_W{1'b0}};
            div_r        <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                DIV_IDLE: begin
                    if (req_valid_i && req_ready_r) begin
                        div_r       <= divisor_i;
                        quot_r      <= dividend_i;
                        rem_r       <= {DATA_W{1'b0}};
                        cnt_r       <= {CNT_W{1'b0}};
                        req_ready_r <= 1'b0;
                        if (divisor_i == {DATA_W{1'b0}}) begin
                            state_r      <= DIV_DONE;
                            resp_valid_r <= 1'b1;
                            quotient_r   <= {DATA_W{1'b1}};
                            remainder_r  <= dividend_i;
                            dbz_r        <= 1'b1;
                        end else begin
                            state_r <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    quot_r <= quot_next_s;
                    rem_r  <= rem_next_s;
                    cnt_r  <= cnt_r + CNT_W'(1);
                    if (cnt_r == CNT_W'(DATA_W - 1)) begin
                        state_r      <= DIV_DONE;
                        resp_valid_r <= 1'b1;
                        quotient_r   <= quot_next_s;
                        remainder_r  <= rem_next_s;
                        dbz_r        <= 1'b0;
                    end
                end
                DIV_DONE: begin
                    // Returning to IDLE here means the next accept is a cycle later.
                    if (resp_valid_r && resp_ready_i) begin
                        state_r      <= DIV_IDLE;
                        resp_valid_r <= 1'b0;
                        req_ready_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= DIV_IDLE;
                    resp_valid_r <= 1'b0;
                    req_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready_o   = req_ready_r;
    assign resp_valid_o  = resp_valid_r;
    assign quotient_o    = quotient_r;
    assign remainder_o   = remainder_r;
    assign div_by_zero_o = dbz_r;

endmodule

// File: tb/tb_divider32_seq.sv
// Self-checking bench for divider32_seq: directed cases plus random pairs,
// expected results queued at accept time and compared at response time.
module tb_divider32_seq;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        dbz;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;

    divider32_seq dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .dividend_i    (dividend),
        .divisor_i     (divisor),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_ready),
        .quotient_o    (quotient),
        .remainder_o   (remainder),
        .div_by_zero_o (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drive a request from a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   guard;
        guard     = 0;
        req_valid = 1'b1;
        dividend  = a;
        divisor   = b;
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        e.q   = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
        e.r   = (b == 32'd0) ? a : a % b;
        e.dbz = (b == 32'd0);
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
    endtask

    // Wait for resp_valid counting clocks since the accept edge (accept edge = 1).
    task automatic wait_resp(input int start_lat, input int exp_lat);
        int lat;
        lat = start_lat;
        while (!resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("resp_valid_seen", {31'd0, resp_valid}, 32'd1);
        check("latency", lat, exp_lat);
    endtask

    // Compare the presented result with the scoreboard head.
    task automatic check_resp(output exp_t e);
        check("sb_size", sb.size(), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
        end else begin
            e.q   = 32'hDEAD_BEEF;
            e.r   = 32'hDEAD_BEEF;
            e.dbz = 1'b1;
        end
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", {31'd0, dbz}, {31'd0, e.dbz});
    endtask

    // Stall the consumer, checking the result holds, then take it.
    task automatic finish_resp(input exp_t e, input int stall);
        resp_ready = 1'b0;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, resp_valid}, 32'd1);
            check("stall_req_ready", {31'd0, req_ready}, 32'd0);
            check("stall_quotient", quotient, e.q);
            check("stall_remainder", remainder, e.r);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check("post_hs_valid", {31'd0, resp_valid}, 32'd0);
        check("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int stall);
        exp_t e;
        send(a, b);
        wait_resp(1, (b == 32'd0) ? 1 : 33);
        check_resp(e);
        finish_resp(e, stall);
    endtask

    initial begin
        exp_t        e;
        logic [31:0] ra;
        logic [31:0] rb;

        rst        = 1'b1;
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        dividend   = 32'd0;
        divisor    = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_remainder", remainder, 32'd0);
        check("rst_dbz", {31'd0, dbz}, 32'd0);

        // Basic divide, consumer always ready.
        resp_ready = 1'b1;
        send(32'd100, 32'd7);
        wait_resp(1, 33);
        check_resp(e);
        finish_resp(e, 0);

        // Zero divisor and edge operands.
        run_op(32'd5, 32'd0, 0);
        run_op(32'hFFFF_FFFF, 32'd1, 1);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(32'hFFFF_FFFF, 32'h8000_0001, 2);

        // A request pulse during BUSY must be ignored.
        send(32'd77777, 32'd13);
        repeat (3) @(negedge clk);
        req_valid = 1'b1;
        dividend  = 32'd50;
        divisor   = 32'd5;
        check("busy_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        wait_resp(5, 33);
        check_resp(e);
        finish_resp(e, 5);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_ghost_resp", {31'd0, resp_valid}, 32'd0);
        end

        // Reset in the middle of an iteration sequence.
        send(32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midrst_idle_valid", {31'd0, resp_valid}, 32'd0);
        end
        run_op(32'd9, 32'd4, 0);

        // Random pairs with random consumer stalls.
        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = $urandom;
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 7) == 0) ra = rb * $urandom_range(0, 9);
            run_op(ra, rb, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
